// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiply-accumulate datapath: product width,
// accumulator FSM encoding and saturation bound helpers.
package booth_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bounds are returned at 64 bits; callers keep the low aw bits.
  function automatic logic signed [63:0] sat_max(input int aw);
    return (64'sd1 <<< (aw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int aw);
    return -(64'sd1 <<< (aw - 1));
  endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Combinational signed adder that clamps to the representable AW-bit range
// instead of wrapping, and flags when it had to clamp.
module sat_add_signed
  import booth_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] y,
  output logic          ovf
);

  localparam logic signed [63:0] MAX_W = sat_max(AW);
  localparam logic signed [63:0] MIN_W = sat_min(AW);
  localparam logic [AW-1:0]      MAX_C = MAX_W[AW-1:0];
  localparam logic [AW-1:0]      MIN_C = MIN_W[AW-1:0];

  logic [AW:0] sum_s;

  // One guard bit: overflow exactly when the top two sum bits disagree.
  always_comb begin
    sum_s = {a[AW-1], a} + {b[AW-1], b};
    ovf   = sum_s[AW] ^ sum_s[AW-1];
    if (!ovf) begin
      y = sum_s[AW-1:0];
    end else if (sum_s[AW]) begin
      y = MIN_C;
    end else begin
      y = MAX_C;
    end
  end

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates up to LEN signed Booth products into one saturating dot product,
// with valid/ready on both sides and a synchronous abort.
module booth_mac_accum
  import booth_pkg::*;
#(
  parameter int PW  = PROD_W,
  parameter int AW  = 24,
  parameter int LEN = 8,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic [CW-1:0] out_count,
  output logic          out_sat
);

  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  state_t        state_r;
  logic [AW-1:0] acc_r;
  logic [CW-1:0] cnt_r;
  logic          sat_r;
  logic          out_valid_r;

  logic [AW-1:0] prod_ext_s;
  logic [AW-1:0] sum_s;
  logic          ovf_s;
  logic [CW-1:0] cnt_nxt_s;
  logic          in_xfer_s;
  logic          out_xfer_s;

  assign prod_ext_s = AW'($signed(in_prod));
  assign cnt_nxt_s  = cnt_r + CW'(1);
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid_r & out_ready;

  sat_add_signed #(.AW(AW)) u_sat_add (
    .a   (acc_r),
    .b   (prod_ext_s),
    .y   (sum_s),
    .ovf (ovf_s)
  );

  // Upstream is stalled only while a finished result waits to be taken.
  always_comb begin
    in_ready = 1'b1;
    case (state_r)
      IDLE:    in_ready = 1'b1;
      ACC:     in_ready = 1'b1;
      DONE:    in_ready = 1'b0;
      default: in_ready = 1'b1;
    endcase
  end

  // Accumulator FSM; clear wins over any same-cycle handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      cnt_r       <= '0;
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (clear) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      cnt_r       <= '0;
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_xfer_s) begin
            acc_r <= prod_ext_s;
            cnt_r <= CW'(1);
            sat_r <= 1'b0;
            if (in_last || (LEN_C == CW'(1))) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= ACC;
              out_valid_r <= 1'b0;
            end
          end
        end
        ACC: begin
          if (in_xfer_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_nxt_s;
            sat_r <= sat_r | ovf_s;
            if (in_last || (cnt_nxt_s == LEN_C)) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_xfer_s) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          acc_r       <= '0;
          cnt_r       <= '0;
          sat_r       <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_acc   = acc_r;
  assign out_count = cnt_r;
  assign out_sat   = sat_r;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Directed bench for booth_mac_accum: a 24-bit and an 18-bit accumulator share
// the same stimulus so saturation can be compared against the unsaturated sum.
module tb_booth_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_acc;
  logic [3:0]  out_count;
  logic        out_sat;

  logic        in_ready18;
  logic        out_valid18;
  logic [17:0] out_acc18;
  logic [3:0]  out_count18;
  logic        out_sat18;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mac_accum dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_sat(out_sat)
  );

  booth_mac_accum #(.AW(18)) dut18 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready18), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid18), .out_ready(out_ready),
    .out_acc(out_acc18), .out_count(out_count18), .out_sat(out_sat18)
  );

  typedef struct {
    int                n;
    logic [7:0][15:0]  p;
    logic              last;
    longint            exp_acc;
    int                exp_cnt;
    logic              exp_sat;
    longint            exp_acc18;
    logic              exp_sat18;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    for (int k = 0; k < v.n; k++) begin
      in_valid = 1'b1;
      in_prod  = v.p[k];
      in_last  = (k == v.n - 1) ? v.last : 1'b0;
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_early_valid"}, out_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_acc"}, $signed(out_acc), v.exp_acc);
    check({tag, "_count"}, out_count, v.exp_cnt);
    check({tag, "_sat"}, out_sat, v.exp_sat);
    check({tag, "_acc18"}, $signed(out_acc18), v.exp_acc18);
    check({tag, "_sat18"}, out_sat18, v.exp_sat18);
    check({tag, "_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_idle"}, in_ready, 1);
  endtask

  task automatic push3(input logic last3);
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_prod  = 16'd5;   @(negedge clk);
    in_prod  = -16'sd7; @(negedge clk);
    in_prod  = 16'd20;  in_last = last3; @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_prod = 16'd0;
    in_last = 1'b0; out_ready = 1'b0;

    vecs[0] = '{n: 8, p: {8{16'h4000}}, last: 1'b0, exp_acc: 131072, exp_cnt: 8,
                exp_sat: 1'b0, exp_acc18: 131071, exp_sat18: 1'b1};
    vecs[1] = '{n: 3, p: '0, last: 1'b1, exp_acc: 18, exp_cnt: 3,
                exp_sat: 1'b0, exp_acc18: 18, exp_sat18: 1'b0};
    vecs[1].p[0] = 16'd5; vecs[1].p[1] = -16'sd7; vecs[1].p[2] = 16'd20;
    vecs[2] = '{n: 8, p: {8{16'hC080}}, last: 1'b0, exp_acc: -130048, exp_cnt: 8,
                exp_sat: 1'b0, exp_acc18: -130048, exp_sat18: 1'b0};
    vecs[3] = '{n: 1, p: {8{16'h8000}}, last: 1'b1, exp_acc: -32768, exp_cnt: 1,
                exp_sat: 1'b0, exp_acc18: -32768, exp_sat18: 1'b0};
    vecs[4] = '{n: 8, p: {8{16'h8000}}, last: 1'b0, exp_acc: -262144, exp_cnt: 8,
                exp_sat: 1'b0, exp_acc18: -131072, exp_sat18: 1'b1};
    vecs[5] = '{n: 8, p: {16'h0000, 16'h8000, 16'h8000, {5{16'h7FFF}}}, last: 1'b0,
                exp_acc: 98299, exp_cnt: 8, exp_sat: 1'b0,
                exp_acc18: 65535, exp_sat18: 1'b1};

    #3;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_acc", out_acc, 0);
    check("reset_count", out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held while upstream keeps offering a product.
    push3(1'b1);
    in_valid = 1'b1; in_prod = 16'd99; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_acc", $signed(out_acc), 18);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_acc", $signed(out_acc), 99);
    check("bp_next_count", out_count, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a sum.
    push3(1'b0);
    check("ar_pre_count", out_count, 3);
    #2 rst = 1'b1;
    #1;
    check("ar_acc", out_acc, 0);
    check("ar_count", out_count, 0);
    check("ar_sat", out_sat, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0], "after_rst");

    // clear together with the 4th transfer in.
    in_valid = 1'b1; in_last = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_prod = 16'(k);
      clear   = (k == 4);
      @(negedge clk);
    end
    clear = 1'b0; in_valid = 1'b0;
    check("clr_in_valid", out_valid, 0);
    check("clr_in_acc", out_acc, 0);
    check("clr_in_count", out_count, 0);
    check("clr_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    check("clr_in_no_result", out_valid, 0);
    in_valid = 1'b1; in_prod = 16'd7; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("clr_in_next_acc", $signed(out_acc), 7);
    check("clr_in_next_count", out_count, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // clear together with a transfer out.
    push3(1'b1);
    check("clr_out_pre_valid", out_valid, 1);
    out_ready = 1'b1; clear = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; clear = 1'b0;
    check("clr_out_valid", out_valid, 0);
    check("clr_out_acc", out_acc, 0);
    check("clr_out_count", out_count, 0);
    check("clr_out_in_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
